// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator: one shared period counter, per-channel duty, edge or
// center alignment, with period/duty/mode double-buffered to cycle boundaries.
module pwm_multi_ch #(
  parameter int CNT_W = 8,
  parameter int N_CH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [CNT_W-1:0]      period_in,
  input  logic [N_CH*CNT_W-1:0] duty_in,
  input  logic                  center_in,
  output logic [N_CH-1:0]       dout,
  output logic                  cycle_start,
  output logic                  upd_pending
);

  // state | meaning
  // IDLE  | counter parked at 0, outputs low, waiting for en
  // RUN   | stepping through PWM frames using the active settings
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      per_sh_q, per_sh_d, per_q, per_d;
  logic [N_CH*CNT_W-1:0] duty_sh_q, duty_sh_d, duty_q, duty_d;
  logic                  ctr_sh_q, ctr_sh_d, ctr_q, ctr_d;
  logic [N_CH-1:0]       dout_q, dout_d;
  logic                  cs_q, cs_d;
  logic                  upd_q, upd_d;

  logic [CNT_W-1:0] per_last;
  logic             zero_per;
  logic             at_top;
  logic             boundary;
  logic             xfer;
  logic             run_act;

  assign per_last = per_q - CNT_W'(1);
  assign zero_per = (per_q == '0);
  assign at_top   = (cnt_q == per_last);
  // Last clock of a frame: top of the ramp in edge mode, bottom of the down-slope in center mode.
  assign boundary = (state_q == RUN) && !zero_per &&
                    (ctr_q ? (dir_q && (cnt_q == '0)) : at_top);
  // A zero active period parks the counter; poll the shadow every clock for a usable one.
  assign xfer     = en && ((state_q == IDLE) || boundary ||
                           ((state_q == RUN) && zero_per && (per_sh_q != '0)));
  assign run_act  = (state_q == RUN) && en && !zero_per;

  function automatic logic ch_hit(input logic [CNT_W-1:0] cnt,
                                  input logic [CNT_W-1:0] duty,
                                  input logic [CNT_W-1:0] per,
                                  input logic             center);
    logic hit;
    if (duty == '0)
      hit = 1'b0;
    else if (duty >= per)
      hit = 1'b1;
    else if (center)
      hit = (cnt >= (per - duty));
    else
      hit = (cnt < duty);
    return hit;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      ctr_sh_q  <= 1'b0;
      per_q     <= '0;
      duty_q    <= '0;
      ctr_q     <= 1'b0;
      dout_q    <= '0;
      cs_q      <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      ctr_sh_q  <= ctr_sh_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      ctr_q     <= ctr_d;
      dout_q    <= dout_d;
      cs_q      <= cs_d;
      upd_q     <= upd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en)  state_d = RUN;
      RUN:  if (!en) state_d = IDLE;
    endcase
  end

  always_comb begin
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    ctr_sh_d  = ctr_sh_q;
    per_d     = per_q;
    duty_d    = duty_q;
    ctr_d     = ctr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;

    if (load) begin
      per_sh_d  = period_in;
      duty_sh_d = duty_in;
      ctr_sh_d  = center_in;
    end

    // Transfer reads the pre-load shadow, so a coincident load waits one more frame.
    if (xfer) begin
      per_d  = per_sh_q;
      duty_d = duty_sh_q;
      ctr_d  = ctr_sh_q;
    end

    if ((state_q == IDLE) || !en || xfer || zero_per) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!ctr_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!dir_q) begin
      if (at_top)
        dir_d = 1'b1;
      else
        cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    upd_d = load ? 1'b1 : (xfer ? 1'b0 : upd_q);
  end

  always_comb begin
    dout_d = '0;
    cs_d   = 1'b0;
    if (run_act) begin
      for (int i = 0; i < N_CH; i++)
        dout_d[i] = ch_hit(cnt_q, duty_q[i*CNT_W +: CNT_W], per_q, ctr_q);
      cs_d = (cnt_q == '0) && !dir_q;
    end
  end

  assign dout        = dout_q;
  assign cycle_start = cs_q;
  assign upd_pending = upd_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: a per-clock vector table for the first edge-mode
// frames, then hand-written sequences for buffering, center mode, enable and reset.
module tb_pwm_multi_ch;

  localparam int CNT_W = 8;
  localparam int N_CH  = 4;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  load;
  logic [CNT_W-1:0]      period_in;
  logic [N_CH*CNT_W-1:0] duty_in;
  logic                  center_in;
  logic [N_CH-1:0]       dout;
  logic                  cycle_start;
  logic                  upd_pending;

  int total = 0;
  int bad   = 0;

  pwm_multi_ch #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .center_in   (center_in),
    .dout        (dout),
    .cycle_start (cycle_start),
    .upd_pending (upd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic                  en;
    logic                  load;
    logic [CNT_W-1:0]      per;
    logic [N_CH*CNT_W-1:0] duty;
    logic                  ctr;
    logic [N_CH-1:0]       exp_dout;
    logic                  exp_cs;
    logic                  exp_upd;
  } vec_t;

  vec_t tv[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // duty packing: {D3, D2, D1, D0}
  localparam logic [31:0] DUTY_T1 = {8'd7, 8'd10, 8'd0, 8'd3};
  localparam logic [31:0] DUTY_T2 = {8'd7, 8'd10, 8'd0, 8'd6};
  localparam logic [31:0] DUTY_T4 = {8'd7, 8'd10, 8'd0, 8'd2};
  localparam logic [31:0] DUTY_T5 = {8'd7, 8'd10, 8'd0, 8'd8};
  localparam logic [31:0] DUTY_P1 = {8'd0, 8'd0, 8'd0, 8'd1};

  initial begin
    int hi;
    int ncs;
    logic [N_CH-1:0] acc;

    rst = 1'b1; en = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0; center_in = 1'b0;

    // Edge mode P=10: vectors 2..12 show counts 0..9,0 on dout.
    tv.push_back('{1'b0, 1'b1, 8'd10, DUTY_T1, 1'b0, 4'b0000, 1'b0, 1'b1});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1101, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1101, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1101, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 8'd10, DUTY_T1, 1'b0, 4'b1101, 1'b1, 1'b0});

    step();
    step();
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset cs", 32'(cycle_start), 32'h0);
    chk("reset upd", 32'(upd_pending), 32'h0);
    rst = 1'b0;

    foreach (tv[i]) begin
      en = tv[i].en; load = tv[i].load; period_in = tv[i].per;
      duty_in = tv[i].duty; center_in = tv[i].ctr;
      step();
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(tv[i].exp_dout));
      chk($sformatf("vec%0d cs", i), 32'(cycle_start), 32'(tv[i].exp_cs));
      chk($sformatf("vec%0d upd", i), 32'(upd_pending), 32'(tv[i].exp_upd));
    end
    load = 1'b0;

    // Duty change mid-frame (count 4) waits for the boundary.
    repeat (3) step();
    load = 1'b1; duty_in = DUTY_T2;
    step();
    load = 1'b0;
    chk("t2 load ch0", 32'(dout[0]), 32'h0);
    chk("t2 load upd", 32'(upd_pending), 32'h1);
    for (int k = 5; k <= 9; k++) begin
      step();
      chk($sformatf("t2 old k%0d ch0", k), 32'(dout[0]), 32'h0);
      chk($sformatf("t2 old k%0d upd", k), 32'(upd_pending), (k < 9) ? 32'h1 : 32'h0);
    end
    hi = 0;
    for (int k = 0; k <= 9; k++) begin
      step();
      hi += int'(dout[0]);
      if (k == 0) chk("t2 new cs", 32'(cycle_start), 32'h1);
      if (k == 5) chk("t2 new k5 ch0", 32'(dout[0]), 32'h1);
      if (k == 6) chk("t2 new k6 ch0", 32'(dout[0]), 32'h0);
    end
    chk("t2 new high clocks", 32'(hi), 32'd6);

    // Load on the boundary edge: P=5 takes effect one frame later.
    repeat (9) step();
    load = 1'b1; period_in = 8'd5; duty_in = DUTY_T4;
    step();
    load = 1'b0;
    chk("t4 boundary upd", 32'(upd_pending), 32'h1);
    ncs = 0;
    hi = 0;
    for (int j = 0; j <= 9; j++) begin
      step();
      ncs += int'(cycle_start);
      hi += int'(dout[0]);
      if (j == 0) chk("t4 old frame cs", 32'(cycle_start), 32'h1);
      if (j == 8) chk("t4 old frame upd", 32'(upd_pending), 32'h1);
      if (j == 9) chk("t4 old frame upd clr", 32'(upd_pending), 32'h0);
    end
    chk("t4 old frame cs count", 32'(ncs), 32'd1);
    chk("t4 old frame high", 32'(hi), 32'd6);
    ncs = 0;
    hi = 0;
    for (int j = 0; j <= 4; j++) begin
      step();
      ncs += int'(cycle_start);
      hi += int'(dout[0]);
    end
    chk("t4 p5 cs count", 32'(ncs), 32'd1);
    chk("t4 p5 high", 32'(hi), 32'd2);
    step();
    chk("t4 p5 next cs", 32'(cycle_start), 32'h1);

    // Center mode P=8, D0=2: 16-clock frame, ch0 high at counts 6,7,7,6.
    load = 1'b1; period_in = 8'd8; duty_in = DUTY_T4; center_in = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    chk("t3 xfer upd", 32'(upd_pending), 32'h0);
    ncs = 0;
    hi = 0;
    for (int j = 0; j <= 15; j++) begin
      step();
      ncs += int'(cycle_start);
      hi += int'(dout[0]);
      if (j == 0) begin
        chk("t3 cs", 32'(cycle_start), 32'h1);
        chk("t3 j0 ch3", 32'(dout[3]), 32'h0);
      end
      if (j == 1) chk("t3 j1 ch3", 32'(dout[3]), 32'h1);
      if (j == 5) chk("t3 j5 ch0", 32'(dout[0]), 32'h0);
      if (j == 6) chk("t3 j6 ch0", 32'(dout[0]), 32'h1);
      if (j == 9) chk("t3 j9 ch0", 32'(dout[0]), 32'h1);
      if (j == 10) chk("t3 j10 ch0", 32'(dout[0]), 32'h0);
    end
    chk("t3 cs count", 32'(ncs), 32'd1);
    chk("t3 high clocks", 32'(hi), 32'd4);
    step();
    chk("t3 next cs", 32'(cycle_start), 32'h1);

    // Back to edge mode P=10 D0=8, then drop en at count 5.
    load = 1'b1; period_in = 8'd10; duty_in = DUTY_T5; center_in = 1'b0;
    step();
    load = 1'b0;
    repeat (14) step();
    repeat (5) step();
    chk("t5 before drop ch0", 32'(dout[0]), 32'h1);
    en = 1'b0;
    step();
    chk("t5 drop dout", 32'(dout), 32'h0);
    chk("t5 drop cs", 32'(cycle_start), 32'h0);
    step();
    chk("t5 idle dout", 32'(dout), 32'h0);
    en = 1'b1;
    step();
    chk("t5 rise dout", 32'(dout), 32'h0);
    chk("t5 rise cs", 32'(cycle_start), 32'h0);
    step();
    chk("t5 restart cs", 32'(cycle_start), 32'h1);
    chk("t5 restart dout", 32'(dout), 32'(4'b1101));

    // Asynchronous reset mid-frame with outputs high and an update pending.
    load = 1'b1;
    step();
    load = 1'b0;
    chk("t6 pre ch0", 32'(dout[0]), 32'h1);
    chk("t6 pre upd", 32'(upd_pending), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 async dout", 32'(dout), 32'h0);
    chk("t6 async cs", 32'(cycle_start), 32'h0);
    chk("t6 async upd", 32'(upd_pending), 32'h0);
    step();
    rst = 1'b0;
    acc = '0;
    for (int j = 0; j < 5; j++) begin
      step();
      acc = acc | dout | {3'b000, cycle_start} | {3'b000, upd_pending};
    end
    chk("t6 p0 quiet", 32'(acc), 32'h0);

    // P=1 picked up from a zero active period; every clock starts a frame.
    load = 1'b1; period_in = 8'd1; duty_in = DUTY_P1; center_in = 1'b0;
    step();
    load = 1'b0;
    chk("p1 load upd", 32'(upd_pending), 32'h1);
    step();
    chk("p1 xfer upd", 32'(upd_pending), 32'h0);
    chk("p1 xfer dout", 32'(dout), 32'h0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("p1 cs%0d", j), 32'(cycle_start), 32'h1);
      chk($sformatf("p1 dout%0d", j), 32'(dout), 32'(4'b0001));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
